mod_divide: RTL and testbench

Modular division unit for the ECEG datapath. It computes result = a · b⁻¹ mod P. It acts as the requesting end of the inversion handshake (enable / x → inverse / outReady), driving an external inversion unit to obtain b⁻¹. It then multiplies by a with an internal bit-serial modular multiplier. It sits between the point-arithmetic sequencer and the shared inversion unit, so slope and affine-conversion steps see one start/done operation.

---
 rtl/mod_divide_pkg.sv | 18 +
 rtl/mod_divide_mult.sv | 60 ++++++
 rtl/mod_divide.sv | 154 +++++++++++++++
 tb/tb_mod_divide.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_divide_pkg.sv
// Shared constants and state encoding for the modular division unit.
// Defaults match the ECEG datapath field (8-bit operands, P = 23).
package mod_divide_pkg;

    localparam int DEF_DATAWIDTH = 8;
    localparam int DEF_P         = 23;
    localparam int DEF_TIMEOUT   = 4096;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_REQ    = 3'd2,
        S_WAIT   = 3'd3,
        S_MULT   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

endpackage

// File: rtl/mod_divide_mult.sv
// Interleaved MSB-first modular multiplier, one bit of b per enabled cycle.
// ready flags the final step; product holds the result the cycle after.
module mod_mult_serial
    import mod_divide_pkg::*;
#(
    parameter int                   DATAWIDTH = DEF_DATAWIDTH,
    parameter logic [DATAWIDTH-1:0] P         = DATAWIDTH'(DEF_P)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] product,
    output logic                 ready
);

    localparam int IW = $clog2(DATAWIDTH);

    logic [IW-1:0]        cnt_q;
    logic [IW-1:0]        idx;
    logic [DATAWIDTH-1:0] acc_q;
    logic [DATAWIDTH-1:0] dbl;
    logic [DATAWIDTH-1:0] nxt;

    // Inputs are < 2P, so one conditional subtract fully reduces.
    function automatic logic [DATAWIDTH-1:0] reduce(
        input logic [DATAWIDTH:0] v
    );
        if (v >= {1'b0, P})
            reduce = DATAWIDTH'(v - {1'b0, P});
        else
            reduce = v[DATAWIDTH-1:0];
    endfunction

    always_comb begin
        idx = IW'(DATAWIDTH - 1) - cnt_q;
        dbl = reduce({acc_q, 1'b0});
        nxt = dbl;
        if (b[idx])
            nxt = reduce({1'b0, dbl} + {1'b0, a});
    end

    assign ready   = enable && (cnt_q == IW'(DATAWIDTH - 1));
    assign product = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (enable) begin
            acc_q <= nxt;
            cnt_q <= cnt_q + 1'b1;
        end else begin
            acc_q <= '0;
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/mod_divide.sv
// Modular division result = a * b^-1 mod P, using an external inversion
// unit for b^-1 and a bit-serial multiplier for the product.
module mod_divide
    import mod_divide_pkg::*;
#(
    parameter int                   DATAWIDTH = DEF_DATAWIDTH,
    parameter logic [DATAWIDTH-1:0] P         = DATAWIDTH'(DEF_P),
    parameter int                   TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] result,
    output logic                 err,
    output logic                 inv_enable,
    output logic [DATAWIDTH-1:0] inv_x,
    input  logic [DATAWIDTH-1:0] inv_result,
    input  logic                 inv_ready
);

    localparam int WW = $clog2(TIMEOUT + 1);

    state_t               state_q;
    state_t               state_d;
    logic [DATAWIDTH-1:0] a_q;
    logic [DATAWIDTH-1:0] b_q;
    logic [DATAWIDTH-1:0] binv_q;
    logic [DATAWIDTH-1:0] binv_d;
    logic [DATAWIDTH-1:0] result_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic                 fail_q;
    logic                 fail_d;
    logic [WW-1:0]        wd_q;
    logic                 wd_hit;
    logic                 bad_op;
    logic                 mul_en;
    logic                 mul_rdy;
    logic [DATAWIDTH-1:0] prod;

    assign wd_hit = (wd_q == WW'(TIMEOUT - 1));
    assign bad_op = (a_q >= P) || (b_q >= P) || (b_q == '0);
    assign mul_en = (state_q == S_MULT);

    always_comb begin
        state_d = state_q;
        binv_d  = binv_q;
        fail_d  = fail_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CHECK;
                    fail_d  = 1'b0;
                end
            end
            S_CHECK: begin
                if (bad_op) begin
                    state_d = S_FINISH;
                    fail_d  = 1'b1;
                end else if (b_q == DATAWIDTH'(1)) begin
                    state_d = S_MULT;
                    binv_d  = DATAWIDTH'(1);
                end else begin
                    state_d = S_REQ;
                end
            end
            // Wait for the responder to clear any stale ready flag.
            S_REQ: begin
                if (wd_hit) begin
                    state_d = S_FINISH;
                    fail_d  = 1'b1;
                end else if (!inv_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (inv_ready) begin
                    state_d = S_MULT;
                    binv_d  = inv_result;
                end else if (wd_hit) begin
                    state_d = S_FINISH;
                    fail_d  = 1'b1;
                end
            end
            S_MULT: begin
                if (mul_rdy)
                    state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            binv_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            fail_q   <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q <= state_d;
            binv_q  <= binv_d;
            fail_q  <= fail_d;
            done_q  <= (state_q == S_FINISH);
            if (state_q == S_IDLE && start) begin
                a_q    <= a;
                b_q    <= b;
                busy_q <= 1'b1;
            end
            if (state_q == S_FINISH) begin
                busy_q   <= 1'b0;
                err_q    <= fail_q;
                result_q <= fail_q ? '0 : prod;
            end
            // One watchdog spans both handshake phases.
            if (state_q == S_REQ || state_q == S_WAIT)
                wd_q <= wd_q + 1'b1;
            else
                wd_q <= '0;
        end
    end

    mod_mult_serial #(
        .DATAWIDTH (DATAWIDTH),
        .P         (P)
    ) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (mul_en),
        .a       (a_q),
        .b       (binv_q),
        .product (prod),
        .ready   (mul_rdy)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign result     = result_q;
    assign inv_enable = (state_q == S_REQ);
    assign inv_x      = b_q;

endmodule

// File: tb/tb_mod_divide.sv
// Directed bench for mod_divide over GF(23) with a modelled inversion unit.
// The responder keeps ready sticky and answers 10 cycles after enable drops.
module tb_mod_divide;

    localparam int TO  = 40;
    localparam int LIM = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       err;
    logic       inv_enable;
    logic [7:0] inv_x;
    logic [7:0] inv_result = '0;
    logic       inv_ready = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    logic       rsp_on = 1'b1;
    int         ack_delay = 1;
    int         en_run = 0;
    int         lat_cnt = 0;
    logic       pend = 1'b0;
    logic [7:0] x_l = '0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       err;
        int         lat;
        int         ens;
    } vec_t;

    vec_t vecs[11];

    mod_divide #(
        .DATAWIDTH (8),
        .P         (8'd23),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .err        (err),
        .inv_enable (inv_enable),
        .inv_x      (inv_x),
        .inv_result (inv_result),
        .inv_ready  (inv_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] inv23(input logic [7:0] x);
        inv23 = '0;
        for (int i = 1; i < 23; i++)
            if ((int'(x) * i) % 23 == 1)
                inv23 = 8'(i);
    endfunction

    // Inversion responder model.
    always @(posedge clk) begin
        if (inv_enable) begin
            en_run  <= en_run + 1;
            x_l     <= inv_x;
            pend    <= rsp_on;
            lat_cnt <= 0;
            if (en_run + 1 >= ack_delay)
                inv_ready <= 1'b0;
        end else begin
            en_run <= 0;
            if (pend) begin
                lat_cnt <= lat_cnt + 1;
                if (lat_cnt == 9) begin
                    inv_ready  <= 1'b1;
                    inv_result <= inv23(x_l);
                    pend       <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic run(
        input  logic [7:0] ia,
        input  logic [7:0] ib,
        output logic [7:0] r,
        output logic       e,
        output int         lat,
        output int         ens,
        output logic       ok,
        output logic       ovl
    );
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = ia;
        b     = ib;
        lat   = 0;
        ens   = 0;
        ovl   = 1'b0;
        do begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (inv_enable) ens++;
            if (busy && done) ovl = 1'b1;
        end while (!done && lat < LIM);
        ok = done;
        r  = result;
        e  = err;
    endtask

    initial begin
        logic [7:0] r;
        logic       e;
        logic       ok;
        logic       ovl;
        int         lat;
        int         ens;
        int         k;

        vecs[0]  = '{8'd5,  8'd3,  8'd17, 1'b0, 0,  1};
        vecs[1]  = '{8'd7,  8'd1,  8'd7,  1'b0, 11, 0};
        vecs[2]  = '{8'd4,  8'd0,  8'd0,  1'b1, 3,  0};
        vecs[3]  = '{8'd23, 8'd5,  8'd0,  1'b1, 3,  0};
        vecs[4]  = '{8'd5,  8'd23, 8'd0,  1'b1, 3,  0};
        vecs[5]  = '{8'd10, 8'd5,  8'd2,  1'b0, 0,  2};
        vecs[6]  = '{8'd1,  8'd2,  8'd12, 1'b0, 0,  2};
        vecs[7]  = '{8'd22, 8'd1,  8'd22, 1'b0, 11, 0};
        vecs[8]  = '{8'd0,  8'd7,  8'd0,  1'b0, 0,  2};
        vecs[9]  = '{8'd1,  8'd22, 8'd22, 1'b0, 0,  2};
        vecs[10] = '{8'd15, 8'd17, 8'd9,  1'b0, 0,  2};

        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst result", result, 0);
        chk("rst inv_enable", inv_enable, 0);
        chk("rst inv_x", inv_x, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run(vecs[i].a, vecs[i].b, r, e, lat, ens, ok, ovl);
            chk($sformatf("v%0d done", i), ok, 1);
            chk($sformatf("v%0d result", i), r, vecs[i].res);
            chk($sformatf("v%0d err", i), e, vecs[i].err);
            chk($sformatf("v%0d enables", i), ens, vecs[i].ens);
            chk($sformatf("v%0d busy&done", i), ovl, 0);
            if (vecs[i].lat != 0)
                chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d done pulse", i), done, 0);
        end

        // Responder silent: watchdog must fire.
        rsp_on = 1'b0;
        run(8'd5, 8'd3, r, e, lat, ens, ok, ovl);
        chk("timeout done", ok, 1);
        chk("timeout err", e, 1);
        chk("timeout result", r, 0);
        chk("timeout latency", lat, TO + 3);
        chk("timeout inv_enable", inv_enable, 0);
        rsp_on = 1'b1;

        // Prime a sticky ready, then make the responder slow to clear it.
        run(8'd1, 8'd2, r, e, lat, ens, ok, ovl);
        chk("prime result", r, 12);
        ack_delay = 4;
        run(8'd22, 8'd22, r, e, lat, ens, ok, ovl);
        chk("stale result", r, 1);
        chk("stale err", e, 0);
        chk("stale enables", ens, 5);
        ack_delay = 1;

        // start while busy is ignored; next start taken in the done cycle.
        @(posedge clk);
        #1;
        start = 1'b1;
        a = 8'd10;
        b = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        a = 8'd1;
        b = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!done && k < LIM) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("busy-start done", done, 1);
        chk("busy-start result", result, 2);
        start = 1'b1;
        a = 8'd22;
        b = 8'd1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end while (!done && lat < LIM);
        chk("b2b result", result, 22);
        chk("b2b latency", lat, 11);

        // Asynchronous reset in the middle of the multiply.
        @(posedge clk);
        #1;
        start = 1'b1;
        a = 8'd5;
        b = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!inv_ready && k < LIM) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("mid ready seen", inv_ready, 1);
        repeat (3) @(posedge clk);
        #2;
        chk("mid busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst busy", busy, 0);
        chk("arst done", done, 0);
        chk("arst result", result, 0);
        chk("arst inv_enable", inv_enable, 0);
        chk("arst inv_x", inv_x, 0);
        k = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) k++;
        end
        chk("arst no done", k, 0);
        rst_n = 1'b1;
        run(8'd5, 8'd3, r, e, lat, ens, ok, ovl);
        chk("post-rst done", ok, 1);
        chk("post-rst result", r, 17);
        chk("post-rst err", e, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
